// File: rtl/frac_div_sched.sv
// Fractional S/D period scheduler: a sequential divider yields q/r, then an error accumulator picks q or q+1 per period.
// New ratios load only at period boundaries; cfg_ready is low while a ratio is being computed or is waiting to load.
module frac_div_sched #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_s,
  input  logic [W-1:0] cfg_d,
  output logic         cfg_err,
  input  logic         en,
  output logic         clk_div,
  output logic         period_start,
  output logic [W:0]   cur_div,
  output logic         running
);

  localparam int SW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, RUN, PEND} state_t;

  state_t         state_q, state_d;
  logic           from_run_q, from_run_d;
  logic [W-1:0]   nd_q, nd_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [SW-1:0]  step_q, step_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   r_q, r_d;
  logic [W-1:0]   d_q, d_d;
  logic [W:0]     acc_q, acc_d;
  logic [W:0]     cnt_q, cnt_d;
  logic [W:0]     n_q, n_d;
  logic           clk_div_q, clk_div_d;
  logic           ps_q, ps_d;
  logic           run_q, run_d;
  logic           err_q, err_d;

  // Restoring divider step
  logic [W:0]     trial;
  logic           ge;
  logic [W-1:0]   rem_nxt;
  logic [W-1:0]   quo_nxt;

  // Scheduling
  logic           hs, bad;
  logic           calc_done, use_new, have_ratio, bnd, start, ld, long_p;
  logic [W-1:0]   eff_q, eff_r, eff_d;
  logic [W:0]     acc_base, a_sum;
  logic [W+1:0]   half;

  assign cfg_ready    = (state_q == IDLE) || (state_q == RUN);
  assign cfg_err      = err_q;
  assign clk_div      = clk_div_q;
  assign period_start = ps_q;
  assign cur_div      = n_q;
  assign running      = run_q;

  always_comb begin
    trial   = {rem_q, quo_q[W-1]};
    ge      = trial >= {1'b0, nd_q};
    rem_nxt = ge ? (trial[W-1:0] - nd_q) : trial[W-1:0];
    quo_nxt = {quo_q[W-2:0], ge};
  end

  always_comb begin
    hs  = cfg_valid && cfg_ready;
    bad = (cfg_d == '0) || ({1'b0, cfg_s} < {cfg_d, 1'b0});

    calc_done  = (state_q == CALC) && (step_q == SW'(W - 1));
    use_new    = calc_done || (state_q == PEND);
    have_ratio = (state_q == RUN) || (state_q == PEND) ||
                 ((state_q == CALC) && from_run_q) || calc_done;

    // In the final CALC cycle the divider result is still combinational
    eff_q = use_new ? ((state_q == CALC) ? quo_nxt : quo_q) : q_q;
    eff_r = use_new ? ((state_q == CALC) ? rem_nxt : rem_q) : r_q;
    eff_d = use_new ? nd_q : d_q;

    bnd   = !run_q || (cnt_q == n_q - 1'b1);
    start = bnd && en && have_ratio;
    ld    = use_new && (start || (calc_done && !from_run_q));

    acc_base = ld ? '0 : acc_q;
    a_sum    = acc_base + {1'b0, eff_r};
    long_p   = a_sum >= {1'b0, eff_d};
  end

  always_comb begin
    state_d    = state_q;
    from_run_d = from_run_q;
    nd_d       = nd_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    step_d     = step_q;
    q_d        = q_q;
    r_d        = r_q;
    d_d        = d_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    run_d      = run_q;
    ps_d       = 1'b0;
    err_d      = hs && bad;

    case (state_q)
      IDLE, RUN: begin
        if (hs && !bad) begin
          state_d    = CALC;
          from_run_d = (state_q == RUN);
          nd_d       = cfg_d;
          quo_d      = cfg_s;
          rem_d      = '0;
          step_d     = '0;
        end
      end
      CALC: begin
        quo_d  = quo_nxt;
        rem_d  = rem_nxt;
        step_d = step_q + SW'(1);
        if (calc_done) begin
          state_d = (start || !from_run_q) ? RUN : PEND;
        end
      end
      PEND: begin
        if (start) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ld) begin
      q_d   = eff_q;
      r_d   = eff_r;
      d_d   = eff_d;
      acc_d = '0;
    end

    if (start) begin
      n_d   = long_p ? ({1'b0, eff_q} + 1'b1) : {1'b0, eff_q};
      acc_d = long_p ? (a_sum - {1'b0, eff_d}) : a_sum;
      cnt_d = '0;
      run_d = 1'b1;
      ps_d  = 1'b1;
    end else if (run_q && !bnd) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      // Boundary with en low: hold cnt/acc, stop producing periods
      run_d = 1'b0;
    end

    half      = ({1'b0, n_d} + (W+2)'(1)) >> 1;
    clk_div_d = run_d && ({1'b0, cnt_d} < half);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      from_run_q <= 1'b0;
      nd_q       <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      step_q     <= '0;
      q_q        <= '0;
      r_q        <= '0;
      d_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      n_q        <= '0;
      clk_div_q  <= 1'b0;
      ps_q       <= 1'b0;
      run_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      from_run_q <= from_run_d;
      nd_q       <= nd_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      step_q     <= step_d;
      q_q        <= q_d;
      r_q        <= r_d;
      d_q        <= d_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      clk_div_q  <= clk_div_d;
      ps_q       <= ps_d;
      run_q      <= run_d;
      err_q      <= err_d;
    end
  end

endmodule
